// File: rtl/ext_trig_rx.sv
// ext_trig_rx: receive-side qualifier for the shared external trigger line.
// Synchronises and glitch-filters the line, blanks echoes of our own drive,
// applies a programmable holdoff and hands accepted triggers to the
// acquisition logic as a one-cycle pulse plus a valid/ready event record.
// Optional feature: define EXT_TRIG_TIMESTAMP_EN to add the timestamp input
// and the trig_ts field of the event record.
module ext_trig_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned BLANK_CYC   = 8,
  parameter int unsigned HOLDOFF_W   = 16,
  parameter int unsigned CNT_W       = 32
`ifdef EXT_TRIG_TIMESTAMP_EN
  ,
  parameter int unsigned TS_W        = 48
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ext_trig_maroc,
  input  logic                 pixel_trig_maroc,
  input  logic                 enable,
  input  logic [HOLDOFF_W-1:0] holdoff_cyc,
`ifdef EXT_TRIG_TIMESTAMP_EN
  input  logic [TS_W-1:0]      timestamp,
  output logic [TS_W-1:0]      trig_ts,
`endif
  output logic                 trig_pulse,
  output logic                 trig_valid,
  input  logic                 trig_ready,
  output logic [CNT_W-1:0]     trig_id,
  output logic [CNT_W-1:0]     trig_count,
  output logic [15:0]          drop_count,
  output logic                 busy
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned BCNT_W = $clog2(BLANK_CYC + 1);
  localparam int unsigned DROP_W = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] ext_sync;
  logic [SYNC_STAGES-1:0] pix_sync;
  logic                   ext_s;
  logic                   pix_s;

  logic [FCNT_W-1:0]      flt_cnt;
  logic                   filt;
  logic                   filt_d;
  logic [BCNT_W-1:0]      blank_cnt;

  logic                   rise;
  logic                   blank;
  logic                   qual;
  logic                   slot_free;

  state_t                 state_q;
  state_t                 state_n;
  logic [HOLDOFF_W-1:0]   hold_q;
  logic [HOLDOFF_W-1:0]   hold_n;
  logic                   load;
  logic                   drop_ev;
  logic                   pulse_n;
  logic                   valid_n;
  logic [CNT_W-1:0]       id_n;
  logic [CNT_W-1:0]       count_n;
  logic [DROP_W-1:0]      drop_n;

  assign ext_s     = ext_sync[SYNC_STAGES-1];
  assign pix_s     = pix_sync[SYNC_STAGES-1];
  assign rise      = filt & ~filt_d;
  assign blank     = pix_s | (blank_cnt != '0);
  assign qual      = rise & ~blank & enable;
  assign slot_free = ~trig_valid | trig_ready;

  // Two-flop (or deeper) synchronisers for both async inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync <= '0;
      pix_sync <= '0;
    end else begin
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_trig_maroc};
      pix_sync <= {pix_sync[SYNC_STAGES-2:0], pixel_trig_maroc};
    end
  end

  // Glitch filter: level flips only after FILTER_LEN consecutive opposite samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
    end else begin
      filt_d <= filt;
      if (ext_s == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
        filt    <= ext_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FCNT_W'(1);
      end
    end
  end

  // Echo blanking: held while we drive the line and BLANK_CYC cycles after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
    end else if (pix_s) begin
      blank_cnt <= BCNT_W'(BLANK_CYC);
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - BCNT_W'(1);
    end
  end

  // FSM state, holdoff counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      trig_pulse <= 1'b0;
      trig_valid <= 1'b0;
      trig_id    <= '0;
      trig_count <= '0;
      drop_count <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      hold_q     <= hold_n;
      trig_pulse <= pulse_n;
      trig_valid <= valid_n;
      trig_id    <= id_n;
      trig_count <= count_n;
      drop_count <= drop_n;
      busy       <= (state_n == HOLDOFF);
    end
  end

  // Next-state: accept, drop or time out holdoff; record handshake
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    load    = 1'b0;
    drop_ev = 1'b0;
    pulse_n = 1'b0;
    valid_n = trig_valid;
    id_n    = trig_id;
    count_n = trig_count;
    drop_n  = drop_count;

    if (trig_valid && trig_ready) begin
      valid_n = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (qual) begin
          if (slot_free) begin
            load = 1'b1;
          end else begin
            drop_ev = 1'b1;
          end
        end
      end
      HOLDOFF: begin
        hold_n = hold_q - HOLDOFF_W'(1);
        if (hold_q <= HOLDOFF_W'(1)) begin
          state_n = IDLE;
        end
        if (qual) begin
          drop_ev = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (load) begin
      pulse_n = 1'b1;
      count_n = trig_count + CNT_W'(1);
      id_n    = count_n;
      valid_n = 1'b1;
      hold_n  = holdoff_cyc;
      state_n = (holdoff_cyc == '0) ? IDLE : HOLDOFF;
    end

    if (drop_ev && (drop_count != '1)) begin
      drop_n = drop_count + DROP_W'(1);
    end
  end

`ifdef EXT_TRIG_TIMESTAMP_EN
  // Timestamp field of the record, captured in the accepting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_ts <= '0;
    end else if (state_q == IDLE && qual && slot_free) begin
      trig_ts <= timestamp;
    end
  end
`endif

endmodule

// File: tb/tb_ext_trig_rx.sv
// Testbench for ext_trig_rx: directed vector table, hand-written holdoff,
// backpressure and reset sequences, then randomized traffic; every cycle is
// compared against a behavioural model built from the filtering, blanking,
// holdoff and handshake rules over the recorded input history.
module tb_ext_trig_rx;

  localparam int S = 2;
  localparam int F = 4;
  localparam int B = 8;
  localparam int N = 8192;

  logic        clk;
  logic        rst_n;
  logic        ext;
  logic        pix;
  logic        en;
  logic [15:0] hold;
  logic        rdy;
  logic [47:0] ts;
  logic        trig_pulse;
  logic        trig_valid;
  logic [31:0] trig_id;
  logic [31:0] trig_count;
  logic [15:0] drop_count;
  logic        busy;
`ifdef EXT_TRIG_TIMESTAMP_EN
  logic [47:0] trig_ts;
`endif

  ext_trig_rx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ext_trig_maroc   (ext),
    .pixel_trig_maroc (pix),
    .enable           (en),
    .holdoff_cyc      (hold),
`ifdef EXT_TRIG_TIMESTAMP_EN
    .timestamp        (ts),
    .trig_ts          (trig_ts),
`endif
    .trig_pulse       (trig_pulse),
    .trig_valid       (trig_valid),
    .trig_ready       (rdy),
    .trig_id          (trig_id),
    .trig_count       (trig_count),
    .drop_count       (drop_count),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_seen = 0;
  int busy_seen  = 0;

  // recorded input history, index = clock edge number since reset release
  bit          ext_a  [N];
  bit          pix_a  [N];
  bit          en_a   [N];
  bit          rdy_a  [N];
  int          hold_a [N];
  logic [47:0] ts_a   [N];
  bit          filt_a [N];

  // model state
  logic [31:0] m_count;
  logic [31:0] m_id;
  logic [15:0] m_drop;
  logic        m_valid;
  logic        m_pulse;
  logic        m_busy;
  logic [47:0] m_ts;
  int          dead_until;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      ext_a[i] = 0; pix_a[i] = 0; en_a[i] = 0; rdy_a[i] = 0;
      hold_a[i] = 0; ts_a[i] = '0; filt_a[i] = 0;
    end
    m_count = '0; m_id = '0; m_drop = '0; m_valid = 0; m_pulse = 0;
    m_busy = 0; m_ts = '0; dead_until = 0; cyc = 0;
  endtask

  // Model for clock edge e, from the recorded inputs
  task automatic model_edge(input int e);
    bit v, all_eq, s, rise, bl, q;
    int idx;
    // filtered level: flips when the last F synchronised samples all oppose it
    v = !filt_a[e-1];
    all_eq = (e >= F);
    for (int j = e - F + 1; j <= e; j++) begin
      idx = j - S;
      s = (idx >= 1) ? ext_a[idx] : 1'b0;
      if (s != v) all_eq = 1'b0;
    end
    filt_a[e] = all_eq ? v : filt_a[e-1];
    rise = (e >= 2) && filt_a[e-1] && !filt_a[e-2];
    // blanked if synced pixel drive was high anywhere in the last B+1 cycles
    bl = 1'b0;
    for (int m = e - 1 - B; m <= e - 1; m++) begin
      idx = m - S + 1;
      if (idx >= 1 && pix_a[idx]) bl = 1'b1;
    end
    q = rise && !bl && en_a[e];
    m_pulse = 1'b0;
    if (q && e > dead_until && (!m_valid || rdy_a[e])) begin
      m_count    = m_count + 32'd1;
      m_id       = m_count;
      m_valid    = 1'b1;
      m_pulse    = 1'b1;
      m_ts       = ts_a[e];
      dead_until = e + hold_a[e];
    end else begin
      if (q && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      if (m_valid && rdy_a[e]) m_valid = 1'b0;
    end
    m_busy = (e < dead_until);
  endtask

  // Apply current inputs for one clock edge and compare against the model
  task automatic step();
    if (cyc >= N - 2) begin
      $display("FAIL history overflow at cyc %0d", cyc);
      $fatal(1);
    end
    ts = 48'h0100_0000_0000 + 48'(cyc + 1);
    ext_a[cyc+1] = ext; pix_a[cyc+1] = pix; en_a[cyc+1] = en;
    rdy_a[cyc+1] = rdy; hold_a[cyc+1] = int'(hold); ts_a[cyc+1] = ts;
    @(posedge clk);
    cyc++;
    model_edge(cyc);
    #1;
    pulse_seen += int'(trig_pulse);
    busy_seen  += int'(busy);
    chk("trig_pulse", 64'(trig_pulse), 64'(m_pulse));
    chk("trig_valid", 64'(trig_valid), 64'(m_valid));
    chk("trig_id",    64'(trig_id),    64'(m_id));
    chk("trig_count", 64'(trig_count), 64'(m_count));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("busy",       64'(busy),       64'(m_busy));
`ifdef EXT_TRIG_TIMESTAMP_EN
    chk("trig_ts",    64'(trig_ts),    64'(m_ts));
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pulse"}, 64'(trig_pulse), 64'd0);
    chk({tag, "_valid"}, 64'(trig_valid), 64'd0);
    chk({tag, "_id"},    64'(trig_id),    64'd0);
    chk({tag, "_count"}, 64'(trig_count), 64'd0);
    chk({tag, "_drop"},  64'(drop_count), 64'd0);
    chk({tag, "_busy"},  64'(busy),       64'd0);
  endtask

  typedef struct {
    int ext_len;
    int pix_len;
    bit loop_line;
    int gap;
    bit en;
    int exp_pulse;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int p0, d0, c0, b0;
    logic [31:0] base;
    int run;

    vecs[0] = '{20, 0, 0, 0, 1, 1};  // clean trigger
    vecs[1] = '{3,  0, 0, 0, 1, 0};  // glitch shorter than filter
    vecs[2] = '{4,  0, 0, 0, 1, 1};  // exactly filter length
    vecs[3] = '{10, 0, 0, 0, 0, 0};  // disabled
    vecs[4] = '{10, 10, 1, 9, 1, 1}; // self echo, then real trigger
    vecs[5] = '{10, 2, 0, 3, 1, 0};  // rise inside blank window
    vecs[6] = '{10, 2, 0, 4, 1, 1};  // rise just after blank window

    rst_n = 1'b0; ext = 0; pix = 0; en = 1; rdy = 1; hold = '0; ts = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // first trigger latency: pulse on edge S+F+1 after line goes high
    ext = 1;
    steps(6);
    chk("latency_pre", 64'(trig_pulse), 64'd0);
    step();
    chk("latency_pulse", 64'(trig_pulse), 64'd1);
    chk("first_id", 64'(trig_id), 64'd1);
    steps(13);
    ext = 0;
    steps(30);
    chk("first_count", 64'(trig_count), 64'd1);

    // vector table
    for (int k = 0; k < 7; k++) begin
      p0 = pulse_seen; d0 = int'(drop_count);
      en = vecs[k].en; hold = '0; rdy = 1;
      if (vecs[k].pix_len > 0) begin
        pix = 1; ext = vecs[k].loop_line;
        steps(vecs[k].pix_len);
        pix = 0; ext = 0;
        steps(vecs[k].gap);
      end
      ext = 1; steps(vecs[k].ext_len);
      ext = 0; steps(30);
      en = 1;
      chk($sformatf("vec%0d_pulses", k), 64'(pulse_seen - p0), 64'(vecs[k].exp_pulse));
      chk($sformatf("vec%0d_drops", k), 64'(int'(drop_count) - d0), 64'd0);
    end

    // holdoff: 2nd rise dropped, 3rd accepted; mid-holdoff reprogram applies next load
    c0 = int'(trig_count); d0 = int'(drop_count); b0 = busy_seen;
    hold = 16'd100;
    ext = 1; steps(10); ext = 0; steps(40);
    ext = 1; steps(10); hold = 16'd5; ext = 0; steps(90);
    ext = 1; steps(10); ext = 0; steps(40);
    chk("holdoff_count", 64'(int'(trig_count) - c0), 64'd2);
    chk("holdoff_drop",  64'(int'(drop_count) - d0), 64'd1);
    chk("holdoff_busy",  64'(busy_seen - b0),        64'd105);

    // backpressure
    hold = '0; rdy = 0; base = m_count; d0 = int'(drop_count);
    ext = 1; steps(10); ext = 0; steps(20);
    ext = 1; steps(10); ext = 0; steps(20);
    chk("bp_valid", 64'(trig_valid), 64'd1);
    chk("bp_id",    64'(trig_id),    64'(base + 32'd1));
    chk("bp_drop",  64'(int'(drop_count) - d0), 64'd1);
    ext = 1; steps(6);
    rdy = 1; step(); rdy = 0;
    chk("bp_swap_pulse", 64'(trig_pulse), 64'd1);
    chk("bp_swap_valid", 64'(trig_valid), 64'd1);
    chk("bp_swap_id",    64'(trig_id),    64'(base + 32'd2));
    steps(3); ext = 0; steps(20);
    chk("bp_hold_id", 64'(trig_id), 64'(base + 32'd2));
    rdy = 1; steps(2);
    chk("bp_drained", 64'(trig_valid), 64'd0);

    // asynchronous reset in the middle of holdoff
    hold = 16'd50; ext = 1; steps(10);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0; ext = 0;
    #2;
    check_reset_outputs("midreset");
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic
    run = 0;
    for (int i = 0; i < 2500; i++) begin
      if (run == 0) begin
        ext = ~ext;
        run = int'($urandom_range(1, 12));
      end
      run--;
      if ($urandom_range(0, 60) == 0) pix = 1;
      else if (pix && $urandom_range(0, 3) == 0) pix = 0;
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 50) == 0) hold = 16'($urandom_range(0, 25));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
